data_mem_io: RTL

Data memory with memory-mapped output port for the single-cycle core. Sits directly downstream of the datapath: consumes its ALU result as a byte address, its store data and the memWrite control, and returns load data on readData in the same cycle. The upper half of the address space holds a small MMIO window with a transmit FIFO (valid/ready towards an external consumer), a status register and an optional cycle counter.

---
 rtl/data_mem_io.sv | 130 +++++++++++++
 1 files changed

// File: rtl/data_mem_io.sv
// data_mem_io: word-addressed data RAM plus an MMIO window (transmit FIFO,
// status register, optional cycle counter) for the single-cycle core.
// Optional feature macro: DATA_MEM_CYCLE_COUNTER_EN (free-running cycle counter
// readable at the CYCLE register; CYCLE reads 0 when undefined).
module data_mem_io #(
  parameter int n          = 32,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memWrite,
  input  logic [n-1:0] address,
  input  logic [n-1:0] writeData,
  output logic [n-1:0] readData,
  output logic [n-1:0] ioData,
  output logic         ioValid,
  input  logic         ioReady
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [n-1:0]  ram_q  [DEPTH];
  logic [n-1:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cyc_val;

  // Address decode: bit 31 picks MMIO, bits [3:2] select the register.
  logic          is_mmio;
  logic [1:0]    off;
  logic [AW-1:0] widx;
  assign is_mmio = address[31];
  assign off     = address[3:2];
  assign widx    = address[AW+1:2];

  // Bits the decode deliberately ignores (byte offset, aliasing range).
  logic unused_addr;
  assign unused_addr = ^{address[30:AW+2], address[1:0]};

  logic full, empty, pop, push_req, push_ok, stat_wr;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && ioReady;
  assign push_req = memWrite && is_mmio && (off == 2'd0);
  // A full FIFO can still take a word when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign stat_wr  = memWrite && is_mmio && (off == 2'd1);

  assign ioValid = !empty;
  assign ioData  = empty ? '0 : fifo_q[rd_ptr_q];

  // FIFO control and sticky overflow next-state; reset discards push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (push_req && !push_ok)     ovf_d = 1'b1;
      else if (stat_wr && writeData[2]) ovf_d = 1'b0;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    ovf_q    <= ovf_d;
  end

  // Storage arrays: RAM is never reset; FIFO slots are written only on accepted push.
  always_ff @(posedge clk) begin
    if (memWrite && !is_mmio)  ram_q[widx]      <= writeData;
    if (push_ok && !reset)     fifo_q[wr_ptr_q] <= writeData;
  end

`ifdef DATA_MEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  // Free-running counter, zero in the first cycle after reset, wraps naturally.
  always_comb begin
    cyc_d = reset ? 32'h0 : cyc_q + 32'h1;
  end

  // Cycle counter register.
  always_ff @(posedge clk) begin
    cyc_q <= cyc_d;
  end

  assign cyc_val = cyc_q;
`else
  assign cyc_val = 32'h0;
`endif

  // Combinational load path; during reset MMIO reads show reset-state values.
  always_comb begin
    logic [n-1:0] status;
    status = '0;
    if (reset) begin
      status[1] = 1'b1;
    end else begin
      status[0]         = full;
      status[1]         = empty;
      status[2]         = ovf_q;
      status[4 +: CW]   = count_q;
    end
    readData = '0;
    if (!is_mmio) begin
      readData = ram_q[widx];
    end else begin
      case (off)
        2'd1:    readData = status;
        2'd2:    readData = reset ? '0 : n'(cyc_val);
        default: readData = '0;
      endcase
    end
  end
endmodule
